comb_reverb_mc: RTL and testbench

COMB_REVERB_MC -- requirements
Module: comb_reverb_mc

---
 rtl/comb_reverb_mc.sv | 177 +++++++++++++++++
 tb/tb_comb_reverb_mc.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_reverb_mc.sv
// Multi-channel feedback comb filter: time-interleaved channels share one
// delay-line RAM, sequenced by a four-state FSM (one sample per four cycles).
module comb_reverb_mc #(
  parameter int G_DATA_WIDTH       = 16,
  parameter int G_NUM_CHANNELS     = 2,
  parameter int G_DELAY_DEPTH_LOG2 = 10,
  parameter int G_GAIN_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          bypass,
  input  logic [G_DELAY_DEPTH_LOG2-1:0] delay_len,
  input  logic [G_GAIN_WIDTH-1:0]       feedback_gain,
  input  logic [G_GAIN_WIDTH-1:0]       wet_gain,
  input  logic [G_GAIN_WIDTH-1:0]       dry_gain,
  input  logic                          clip_clear,
  output logic                          clip_sticky,
  input  logic [G_DATA_WIDTH-1:0]       din,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic                          din_last,
  output logic [G_DATA_WIDTH-1:0]       dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last
);

  localparam int W     = G_DATA_WIDTH;
  localparam int L     = G_DELAY_DEPTH_LOG2;
  localparam int DEPTH = 1 << L;
  localparam int CW    = (G_NUM_CHANNELS > 1) ? $clog2(G_NUM_CHANNELS) : 1;
  localparam int AW    = $clog2(G_NUM_CHANNELS * DEPTH);
  localparam int PW    = W + G_GAIN_WIDTH + 2;
  localparam logic [CW-1:0]        LAST_CHAN = CW'(G_NUM_CHANNELS - 1);
  localparam logic signed [PW-1:0] SAT_MAX   = PW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] SAT_MIN   = PW'(-(64'sd1 <<< (W - 1)));

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CALC, S_OUT} state_t;

  state_t state, state_next;

  logic [CW-1:0]         chan, chan_q;
  logic [L-1:0]          ptr, fill, d_len, d_eff, rd_ptr;
  logic [AW-1:0]         rd_addr, wr_addr;
  logic signed [W-1:0]   x_q, w_q, ram_q, d_val, w_sat, y_sat;
  logic                  byp_q, zero_q, w_clip, y_clip;
  logic                  in_hs, out_hs, ram_we;
  logic signed [PW-1:0]  x_ext, d_ext, fb_g, wet_g, dry_g, w_sum, y_sum;
  logic signed [W-1:0]   ram [G_NUM_CHANNELS*DEPTH];
  logic                  unused_din_last;

  // Sequencing never looks at din_last; the channel counter alone is authoritative.
  assign unused_din_last = din_last;

  assign din_ready = (state == S_IDLE) && enable && reset_n;
  assign in_hs     = din_valid && din_ready;
  assign out_hs    = dout_valid && dout_ready;
  assign ram_we    = (state == S_OUT) && out_hs && enable;

  assign d_eff   = (chan == '0) ? ((delay_len == '0) ? L'(1) : delay_len) : d_len;
  assign rd_ptr  = ptr - d_eff;
  assign rd_addr = AW'({chan, rd_ptr});
  assign wr_addr = AW'({chan_q, ptr});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_hs) state_next = S_READ;
      S_READ: state_next = S_CALC;
      S_CALC: state_next = S_OUT;
      S_OUT:  if (out_hs) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (!enable) state_next = S_IDLE;
  end

  // Full-width products with zero-extended gains, floor shift, then saturation.
  always_comb begin
    d_val  = zero_q ? '0 : ram_q;
    d_ext  = d_val;
    x_ext  = x_q;
    fb_g   = $signed({1'b0, feedback_gain});
    wet_g  = $signed({1'b0, wet_gain});
    dry_g  = $signed({1'b0, dry_gain});
    w_sum  = x_ext + ((fb_g * d_ext) >>> 15);
    y_sum  = ((dry_g * x_ext) + (wet_g * d_ext)) >>> 15;
    w_clip = 1'b0;
    y_clip = 1'b0;
    w_sat  = w_sum[W-1:0];
    y_sat  = y_sum[W-1:0];
    if (w_sum > SAT_MAX) begin
      w_sat  = SAT_MAX[W-1:0];
      w_clip = 1'b1;
    end else if (w_sum < SAT_MIN) begin
      w_sat  = SAT_MIN[W-1:0];
      w_clip = 1'b1;
    end
    if (byp_q) begin
      y_sat = x_q;
    end else if (y_sum > SAT_MAX) begin
      y_sat  = SAT_MAX[W-1:0];
      y_clip = 1'b1;
    end else if (y_sum < SAT_MIN) begin
      y_sat  = SAT_MIN[W-1:0];
      y_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan        <= '0;
      ptr         <= '0;
      fill        <= '0;
      d_len       <= L'(1);
      chan_q      <= '0;
      x_q         <= '0;
      w_q         <= '0;
      byp_q       <= 1'b0;
      zero_q      <= 1'b1;
      dout        <= '0;
      dout_valid  <= 1'b0;
      dout_last   <= 1'b0;
      clip_sticky <= 1'b0;
    end else if (!enable) begin
      chan        <= '0;
      ptr         <= '0;
      fill        <= '0;
      zero_q      <= 1'b1;
      dout        <= '0;
      dout_valid  <= 1'b0;
      dout_last   <= 1'b0;
      clip_sticky <= 1'b0;
    end else begin
      if (clip_clear) clip_sticky <= 1'b0;
      case (state)
        S_IDLE: if (in_hs) begin
          x_q    <= din;
          byp_q  <= bypass;
          chan_q <= chan;
          zero_q <= (fill < d_eff);
          if (chan == '0) d_len <= d_eff;
        end
        S_CALC: begin
          w_q        <= w_sat;
          dout       <= y_sat;
          dout_valid <= 1'b1;
          dout_last  <= (chan_q == LAST_CHAN);
          if (w_clip || y_clip) clip_sticky <= 1'b1;
        end
        S_OUT: if (out_hs) begin
          dout_valid <= 1'b0;
          if (chan == LAST_CHAN) begin
            chan <= '0;
            ptr  <= ptr + L'(1);
            if (fill != '1) fill <= fill + L'(1);
          end else begin
            chan <= chan + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Delay-line RAM: no reset, so stale words are hidden by the fill mask instead.
  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_addr] <= w_q;
    if (in_hs)  ram_q <= ram[rd_addr];
  end

endmodule

// File: tb/tb_comb_reverb_mc.sv
// Directed bench for comb_reverb_mc with two channels and a 16-entry delay line.
module tb_comb_reverb_mc;

  localparam int W = 16;
  localparam int N = 2;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset_n, enable, bypass, clip_clear, clip_sticky;
  logic [L-1:0] delay_len;
  logic [15:0]  feedback_gain, wet_gain, dry_gain;
  logic [W-1:0] din, dout;
  logic         din_valid, din_ready, din_last, dout_valid, dout_ready, dout_last;

  int checks = 0;
  int errors = 0;
  int tb_chan = 0;

  comb_reverb_mc #(
    .G_DATA_WIDTH(W), .G_NUM_CHANNELS(N), .G_DELAY_DEPTH_LOG2(L), .G_GAIN_WIDTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bypass(bypass),
    .delay_len(delay_len), .feedback_gain(feedback_gain), .wet_gain(wet_gain),
    .dry_gain(dry_gain), .clip_clear(clip_clear), .clip_sticky(clip_sticky),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .din_last(din_last),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last)
  );

  always #5 clk = ~clk;

  task automatic restart(input logic [L-1:0] dl, input logic [15:0] fb, input logic [15:0] wet,
                         input logic [15:0] dry);
    @(negedge clk);
    enable = 1'b0; delay_len = dl; feedback_gain = fb; wet_gain = wet; dry_gain = dry; bypass = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    tb_chan = 0;
  endtask

  task automatic xfer(input logic [W-1:0] x, output logic [W-1:0] y, output logic last, output int lat);
    int guard;
    y = '0; last = 1'b0; lat = -1;
    @(negedge clk);
    din = x; din_valid = 1'b1; din_last = (tb_chan == N - 1);
    guard = 0;
    while (!din_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!din_ready) begin
      checks++; errors++;
      $display("[TB] FAIL din_ready_timeout got 0 expected 1");
      din_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 din_valid = 1'b0;
    lat = 0;
    while (!dout_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!dout_valid) begin
      checks++; errors++;
      $display("[TB] FAIL dout_valid_timeout got 0 expected 1");
      return;
    end
    y = dout; last = dout_last;
    tb_chan = (tb_chan + 1) % N;
  endtask

  task automatic run_frame(input logic [W-1:0] x0, input logic [W-1:0] x1,
                           output logic [W-1:0] y0, output logic [W-1:0] y1,
                           output logic l0, output logic l1);
    int lat;
    xfer(x0, y0, l0, lat);
    xfer(x1, y1, l1, lat);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; enable = 1'b1; bypass = 1'b0; clip_clear = 1'b0; delay_len = 4;
    feedback_gain = 0; wet_gain = 0; dry_gain = 0; din = 0; din_valid = 0; din_last = 0; dout_ready = 1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dout_valid, din_ready, dout_last, clip_sticky} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags got %b expected 0000", {dout_valid, din_ready, dout_last, clip_sticky});
    end
    checks++;
    if (dout !== '0) begin errors++; $display("[TB] FAIL reset_dout got %0d expected 0", dout); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset got %b expected 1", din_ready); end
  endtask

  task automatic test_impulse();
    logic signed [15:0] exp_v [13] = '{1000, 0, 0, 0, 1000, 0, 0, 0, 500, 0, 0, 0, 250};
    logic [W-1:0] y;
    logic last;
    int lat;
    restart(4, 16'h4000, 16'h8000, 16'h8000);
    for (int f = 0; f < 13; f++) begin
      xfer((f == 0) ? 16'd1000 : 16'd0, y, last, lat);
      if (f == 0) begin
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL latency got %0d expected 3", lat); end
      end
      checks++;
      if (y !== exp_v[f] || last !== 1'b0) begin
        errors++; $display("[TB] FAIL impulse_ch0 frame %0d got %0d/%b expected %0d/0", f, $signed(y), last, exp_v[f]);
      end
      xfer(16'd0, y, last, lat);
      checks++;
      if (y !== 16'd0 || last !== 1'b1) begin
        errors++; $display("[TB] FAIL isolation_ch1 frame %0d got %0d/%b expected 0/1", f, $signed(y), last);
      end
    end
  endtask

  task automatic test_negative_floor();
    logic signed [15:0] exp_v [4] = '{-1001, -1001, -501, -251};
    logic [W-1:0] y0, y1;
    logic l0, l1;
    restart(1, 16'h4000, 16'h8000, 16'h8000);
    for (int f = 0; f < 4; f++) begin
      run_frame((f == 0) ? 16'hFC17 : 16'd0, 16'd0, y0, y1, l0, l1);
      checks++;
      if (y0 !== exp_v[f]) begin
        errors++; $display("[TB] FAIL neg_floor frame %0d got %0d expected %0d", f, $signed(y0), exp_v[f]);
      end
    end
  endtask

  task automatic test_delay_zero();
    logic signed [15:0] exp_v [3] = '{1000, 1000, 0};
    logic [W-1:0] y0, y1;
    logic l0, l1;
    restart(0, 16'h0000, 16'h8000, 16'h8000);
    for (int f = 0; f < 3; f++) begin
      run_frame((f == 0) ? 16'd1000 : 16'd0, 16'd0, y0, y1, l0, l1);
      checks++;
      if (y0 !== exp_v[f]) begin
        errors++; $display("[TB] FAIL delay_zero frame %0d got %0d expected %0d", f, $signed(y0), exp_v[f]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] y0, y1;
    logic l0, l1;
    int lat;
    restart(4, 16'h4000, 16'h8000, 16'h4000);
    bypass = 1'b1;
    xfer(16'd1000, y0, l0, lat);
    bypass = 1'b0;
    xfer(16'd0, y1, l1, lat);
    checks++;
    if (y0 !== 16'd1000) begin errors++; $display("[TB] FAIL bypass_out got %0d expected 1000", $signed(y0)); end
    for (int f = 1; f < 4; f++) run_frame(16'd0, 16'd0, y0, y1, l0, l1);
    run_frame(16'd0, 16'd0, y0, y1, l0, l1);
    checks++;
    if (y0 !== 16'd1000) begin errors++; $display("[TB] FAIL bypass_w_written got %0d expected 1000", $signed(y0)); end
    run_frame(16'd1000, 16'd0, y0, y1, l0, l1);
    checks++;
    if (y0 !== 16'd500) begin errors++; $display("[TB] FAIL dry_scaled got %0d expected 500", $signed(y0)); end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] exp_v [4] = '{0, 0, 0, 500};
    logic [W-1:0] y0, y1;
    logic l0, l1;
    int guard, lat;
    restart(4, 16'h4000, 16'h8000, 16'h8000);
    for (int f = 0; f < 4; f++) run_frame((f == 0) ? 16'd1000 : 16'd0, 16'd0, y0, y1, l0, l1);
    @(negedge clk);
    dout_ready = 1'b0; din = 16'd0; din_valid = 1'b1; din_last = 1'b0;
    guard = 0;
    while (!din_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1 din_valid = 1'b0;
    guard = 0;
    while (!dout_valid && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (!dout_valid) begin errors++; $display("[TB] FAIL bp_valid_timeout got 0 expected 1"); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (dout !== 16'd1000 || dout_valid !== 1'b1 || din_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL bp_hold cycle %0d got %0d/%b/%b expected 1000/1/0", c, $signed(dout), dout_valid, din_ready);
      end
    end
    dout_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release got %b expected 0", dout_valid); end
    tb_chan = 1;
    xfer(16'd0, y1, l1, lat);
    for (int f = 0; f < 4; f++) begin
      run_frame(16'd0, 16'd0, y0, y1, l0, l1);
      checks++;
      if (y0 !== exp_v[f]) begin
        errors++; $display("[TB] FAIL bp_sequence frame %0d got %0d expected %0d", f + 5, $signed(y0), exp_v[f]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] y0, y1;
    logic l0, l1;
    restart(1, 16'h8000, 16'h8000, 16'h8000);
    run_frame(16'd30000, 16'd0, y0, y1, l0, l1);
    checks++;
    if (y0 !== 16'd30000 || clip_sticky !== 1'b0) begin
      errors++; $display("[TB] FAIL sat_frame0 got %0d/%b expected 30000/0", $signed(y0), clip_sticky);
    end
    run_frame(16'd30000, 16'd0, y0, y1, l0, l1);
    checks++;
    if (y0 !== 16'd32767 || clip_sticky !== 1'b1) begin
      errors++; $display("[TB] FAIL sat_frame1 got %0d/%b expected 32767/1", $signed(y0), clip_sticky);
    end
    @(negedge clk); clip_clear = 1'b1;
    @(negedge clk); clip_clear = 1'b0;
    checks++;
    if (clip_sticky !== 1'b0) begin errors++; $display("[TB] FAIL clip_clear got %b expected 0", clip_sticky); end
    run_frame(16'd30000, 16'd0, y0, y1, l0, l1);
    checks++;
    if (y0 !== 16'd32767 || clip_sticky !== 1'b1) begin
      errors++; $display("[TB] FAIL sat_frame2 got %0d/%b expected 32767/1", $signed(y0), clip_sticky);
    end
  endtask

  task automatic test_reset_mid_out();
    logic [W-1:0] y;
    logic last;
    int guard, lat;
    @(negedge clk);
    dout_ready = 1'b0; din = 16'd500; din_valid = 1'b1; din_last = 1'b0;
    guard = 0;
    while (!din_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1 din_valid = 1'b0;
    guard = 0;
    while (!dout_valid && guard < 50) begin @(negedge clk); guard++; end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || clip_sticky !== 1'b0 || din_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_out got %b/%b/%b expected 0/0/0", dout_valid, clip_sticky, din_ready);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1; dout_ready = 1'b1; tb_chan = 0;
    xfer(16'd1234, y, last, lat);
    checks++;
    if (y !== 16'd1234 || last !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset_ch0 got %0d/%b expected 1234/0", $signed(y), last);
    end
    xfer(16'd0, y, last, lat);
    checks++;
    if (last !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ch1_last got %b expected 1", last); end
  endtask

  task automatic test_stale_ram();
    logic signed [15:0] exp_v [5] = '{1000, 0, 0, 0, 1000};
    logic [W-1:0] y0, y1;
    logic l0, l1;
    restart(4, 16'h4000, 16'h8000, 16'h8000);
    for (int f = 0; f < 6; f++) begin
      run_frame(16'($urandom_range(0, 20000)) - 16'd10000, 16'($urandom_range(0, 20000)) - 16'd10000,
                y0, y1, l0, l1);
    end
    restart(4, 16'h4000, 16'h8000, 16'h8000);
    for (int f = 0; f < 5; f++) begin
      run_frame((f == 0) ? 16'd1000 : 16'd0, 16'd0, y0, y1, l0, l1);
      checks++;
      if (y0 !== exp_v[f] || y1 !== 16'd0) begin
        errors++; $display("[TB] FAIL stale_ram frame %0d got %0d/%0d expected %0d/0", f, $signed(y0), $signed(y1), exp_v[f]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_negative_floor();
    test_delay_zero();
    test_bypass();
    test_backpressure();
    test_saturation();
    test_reset_mid_out();
    test_stale_ram();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
